// File: rtl/oled_seq_pkg.sv
// ============================================================
// oled_seq_pkg -- shared constants and types for the OLED byte sequencer. Rev 1.0
// ============================================================
`default_nettype none

package oled_seq_pkg;

    localparam int QDEPTH  = 8;
    localparam int ENTRY_W = 9;
    localparam int CNT_W   = 11;
    localparam int QCNT_W  = $clog2(QDEPTH + 1);

    localparam logic [1:0] REG_QUEUE    = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_FILLCNT  = 2'd2;
    localparam logic [1:0] REG_FILLBYTE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QSEND = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/oled_seq_fifo.sv
// ============================================================
// oled_seq_fifo -- circular FIFO exposing the head and the entry behind it. Rev 1.0
// ============================================================
`default_nettype none

module oled_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_next,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full still lands when the same edge frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign dout      = mem[rd_ptr];
    assign dout_next = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/oled_sequencer.sv
// ============================================================
// oled_sequencer -- AHB-Lite slave feeding queued or repeated bytes to a serialiser. Rev 1.0
// ============================================================
`default_nettype none

module oled_sequencer
    import oled_seq_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        BVALID,
    input  logic        BREADY,
    output logic        BDNC,
    output logic [7:0]  BDATA,
    output logic        IRQ
);

    state_t               state;
    logic                 ap_valid;
    logic                 ap_write;
    logic [1:0]           ap_reg;
    logic                 fill_pending;
    logic [CNT_W-1:0]     fill_cnt;
    logic [ENTRY_W-1:0]   fill_byte;
    logic                 ovf;
    logic                 err;
    logic                 irq_en;

    logic                 wr_queue, wr_status, wr_fillcnt, wr_fillbyte;
    logic                 handshake, q_pop, q_full, q_empty, busy;
    logic [QCNT_W-1:0]    q_count;
    logic [ENTRY_W-1:0]   q_head, q_next, fill_byte_eff;
    logic                 unused_bits;

    assign wr_queue    = ap_valid && ap_write && (ap_reg == REG_QUEUE);
    assign wr_status   = ap_valid && ap_write && (ap_reg == REG_STATUS);
    assign wr_fillcnt  = ap_valid && ap_write && (ap_reg == REG_FILLCNT);
    assign wr_fillbyte = ap_valid && ap_write && (ap_reg == REG_FILLBYTE);

    assign handshake = BVALID && BREADY;
    assign q_pop     = (state == ST_QSEND) && handshake;
    assign busy      = (state != ST_IDLE) || fill_pending;
    // Forward a same-edge FILLBYTE write into the byte being loaded.
    assign fill_byte_eff = wr_fillbyte ? HWDATA[ENTRY_W-1:0] : fill_byte;

    assign HREADYOUT = 1'b1;
    assign IRQ       = irq_en && q_empty && !busy;
    assign HRDATA    = (ap_valid && !ap_write && (ap_reg == REG_STATUS))
                     ? {25'b0, irq_en, err, ovf, busy, q_full, q_empty, 1'b0} : 32'b0;
    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:CNT_W]};

    oled_seq_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (wr_queue),
        .pop       (q_pop),
        .din       (HWDATA[ENTRY_W-1:0]),
        .dout      (q_head),
        .dout_next (q_next),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= ST_IDLE;
            ap_valid     <= 1'b0;
            ap_write     <= 1'b0;
            ap_reg       <= 2'd0;
            fill_pending <= 1'b0;
            fill_cnt     <= '0;
            fill_byte    <= '0;
            ovf          <= 1'b0;
            err          <= 1'b0;
            irq_en       <= 1'b0;
            BVALID       <= 1'b0;
            BDNC         <= 1'b0;
            BDATA        <= 8'h00;
        end else begin
            ap_valid <= HREADY && HSEL && (HTRANS != 2'b00);
            ap_write <= HWRITE;
            ap_reg   <= HADDR[3:2];

            if (wr_queue && q_full && !q_pop) ovf <= 1'b1;
            if (wr_status) begin
                if (HWDATA[0]) begin
                    ovf <= 1'b0;
                    err <= 1'b0;
                end
                if (HWDATA[6]) irq_en <= 1'b1;
            end
            if (wr_fillbyte) fill_byte <= HWDATA[ENTRY_W-1:0];
            if (wr_fillcnt) begin
                if (busy || !q_empty) begin
                    err <= 1'b1;
                end else if (HWDATA[CNT_W-1:0] != '0) begin
                    fill_pending <= 1'b1;
                    fill_cnt     <= HWDATA[CNT_W-1:0];
                end
            end

            // Output register reloads whenever it is empty or being consumed.
            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        state <= ST_QSEND;
                    end else if (fill_pending) begin
                        state        <= ST_FILL;
                        fill_pending <= 1'b0;
                    end
                end
                ST_QSEND: begin
                    if (!BVALID || BREADY) begin
                        if (handshake ? (q_count > QCNT_W'(1)) : !q_empty) begin
                            BVALID        <= 1'b1;
                            {BDNC, BDATA} <= handshake ? q_next : q_head;
                        end else begin
                            BVALID <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end
                ST_FILL: begin
                    if (!BVALID || BREADY) begin
                        if (handshake) fill_cnt <= fill_cnt - CNT_W'(1);
                        if (handshake ? (fill_cnt > CNT_W'(1)) : (fill_cnt != '0)) begin
                            BVALID        <= 1'b1;
                            {BDNC, BDATA} <= fill_byte_eff;
                        end else begin
                            BVALID <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_oled_sequencer.sv
// ============================================================
// tb_oled_sequencer -- randomized self-checking bench with a byte-stream reference model. Rev 1.0
// ============================================================
`default_nettype none

module tb_oled_sequencer;

    localparam logic [1:0] A_QUEUE = 2'd0, A_STATUS = 2'd1, A_FILLCNT = 2'd2, A_FILLBYTE = 2'd3;

    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic        HSEL = 1'b0, HREADY = 1'b1, HWRITE = 1'b0;
    logic [31:0] HADDR = '0, HWDATA = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [1:0]  HTRANS = 2'b00;
    logic [31:0] HRDATA;
    logic        HREADYOUT, BVALID, BREADY = 1'b0, BDNC, IRQ;
    logic [7:0]  BDATA;

    int tests = 0, fails = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_b = '0;
    int         stall_viol = 0;

    oled_sequencer dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
        .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .BVALID(BVALID), .BREADY(BREADY), .BDNC(BDNC),
        .BDATA(BDATA), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record every accepted byte and flag any change of a stalled offer.
    always @(posedge HCLK) begin
        if (HRESET) begin
            prev_stall <= 1'b0;
        end else begin
            if (BVALID && BREADY) got.push_back({BDNC, BDATA});
            if (prev_stall && (BVALID !== 1'b1 || {BDNC, BDATA} !== prev_b))
                stall_viol <= stall_viol + 1;
            prev_stall <= BVALID && !BREADY;
            prev_b     <= {BDNC, BDATA};
        end
    end

    task automatic ahb_write(input logic [1:0] r, input logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, r, 2'b00};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [1:0] r, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, r, 2'b00};
        @(negedge HCLK);
        d = HRDATA;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(posedge HCLK); #1;
    endtask

    task automatic wait_got(input int n, input int budget);
        for (int i = 0; i < budget && got.size() < n; i++) @(negedge HCLK);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        tests++; if ({BVALID, BDNC, BDATA} !== 10'h0) begin fails++;
            $display("FAIL reset_bout: got %h expected 000", {BVALID, BDNC, BDATA}); end
        tests++; if (IRQ !== 1'b0 || HREADYOUT !== 1'b1 || HRDATA !== 32'h0) begin fails++;
            $display("FAIL reset_misc: irq=%b hreadyout=%b hrdata=%h expected 0/1/0", IRQ, HREADYOUT, HRDATA); end
        HRESET = 1'b0;
        ahb_read(A_STATUS, rd);
        tests++; if (rd !== 32'h2) begin fails++;
            $display("FAIL reset_status: got %h expected 00000002", rd); end
        ahb_read(A_QUEUE, rd);
        tests++; if (rd !== 32'h0) begin fails++;
            $display("FAIL nonstatus_read: got %h expected 0", rd); end
    endtask

    task automatic test_basic();
        got.delete();
        BREADY = 1'b1;
        ahb_write(A_STATUS, 32'h40);
        ahb_write(A_QUEUE, 32'h0AE);
        @(negedge HCLK);
        tests++; if (BVALID !== 1'b0 || IRQ !== 1'b0) begin fails++;
            $display("FAIL latency_e0: bvalid=%b irq=%b expected 0/0", BVALID, IRQ); end
        @(negedge HCLK);
        tests++; if (BVALID !== 1'b0) begin fails++;
            $display("FAIL latency_e1: bvalid=%b expected 0", BVALID); end
        @(negedge HCLK);
        tests++; if (BVALID !== 1'b1 || {BDNC, BDATA} !== 9'h0AE) begin fails++;
            $display("FAIL latency_e2: bvalid=%b byte=%h expected 1/0ae", BVALID, {BDNC, BDATA}); end
        ahb_write(A_QUEUE, 32'h1FF);
        wait_got(2, 20);
        repeat (2) @(negedge HCLK);
        tests++; if (got.size() != 2 || got[0] !== 9'h0AE || got[1] !== 9'h1FF) begin fails++;
            $display("FAIL basic_order: got %0d bytes first=%h expected 2 bytes 0ae,1ff",
                     got.size(), (got.size() > 0) ? got[0] : 9'h0); end
        tests++; if (IRQ !== 1'b1) begin fails++;
            $display("FAIL basic_irq: got %b expected 1", IRQ); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [8:0]  v;
        got.delete(); exp_q.delete();
        BREADY = 1'b0;
        for (int i = 0; i < 9; i++) begin
            v = 9'($urandom);
            if (exp_q.size() < 8) exp_q.push_back(v);
            ahb_write(A_QUEUE, {23'h0, v});
        end
        ahb_read(A_STATUS, rd);
        tests++; if (rd !== 32'h5C) begin fails++;
            $display("FAIL ovf_status: got %h expected 0000005c", rd); end
        ahb_write(A_STATUS, 32'h41);
        ahb_read(A_STATUS, rd);
        tests++; if (rd !== 32'h4C) begin fails++;
            $display("FAIL ovf_clear: got %h expected 0000004c", rd); end
        BREADY = 1'b1;
        wait_got(8, 40);
        repeat (3) @(negedge HCLK);
        tests++; if (got.size() != 8) begin fails++;
            $display("FAIL ovf_drain_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            tests++; if (got[i] !== exp_q[i]) begin fails++;
                $display("FAIL ovf_drain_data[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
        ahb_read(A_STATUS, rd);
        tests++; if (rd !== 32'h42) begin fails++;
            $display("FAIL ovf_idle_status: got %h expected 00000042", rd); end
    endtask

    task automatic test_fill();
        logic [31:0] rd;
        int early = 0, bad = 0;
        got.delete();
        BREADY = 1'b1;
        ahb_write(A_FILLBYTE, 32'h100);
        ahb_write(A_FILLCNT, 32'd1024);
        for (int i = 0; i < 1200 && got.size() < 1024; i++) begin
            @(negedge HCLK);
            if (got.size() < 1024 && IRQ !== 1'b0) early++;
        end
        tests++; if (IRQ !== 1'b1 || BVALID !== 1'b0) begin fails++;
            $display("FAIL fill_busy_drop: irq=%b bvalid=%b expected 1/0", IRQ, BVALID); end
        tests++; if (early != 0) begin fails++;
            $display("FAIL fill_busy_early: got %0d idle cycles expected 0", early); end
        repeat (4) @(negedge HCLK);
        foreach (got[i]) if (got[i] !== 9'h100) bad++;
        tests++; if (got.size() != 1024 || bad != 0) begin fails++;
            $display("FAIL fill_1024: got %0d bytes (%0d wrong) expected 1024 of 100", got.size(), bad); end
        ahb_read(A_STATUS, rd);
        tests++; if (rd !== 32'h42) begin fails++;
            $display("FAIL fill_status: got %h expected 00000042", rd); end
    endtask

    task automatic test_fill_random();
        int n, bad;
        logic [8:0] b;
        for (int r = 0; r < 3; r++) begin
            got.delete(); bad = 0;
            n = $urandom_range(1, 20);
            b = 9'($urandom);
            BREADY = 1'b0;
            ahb_write(A_FILLBYTE, {23'h0, b});
            ahb_write(A_FILLCNT, n);
            for (int i = 0; i < 400 && got.size() < n; i++) begin
                @(negedge HCLK); BREADY = 1'($urandom);
            end
            BREADY = 1'b1;
            repeat (5) @(negedge HCLK);
            foreach (got[i]) if (got[i] !== b) bad++;
            tests++; if (got.size() != n || bad != 0) begin fails++;
                $display("FAIL fill_rand: got %0d bytes (%0d wrong) expected %0d of %h", got.size(), bad, n, b); end
        end
    endtask

    task automatic test_push_during_fill();
        logic [8:0] b, e0, e1;
        got.delete(); exp_q.delete();
        b = 9'($urandom); e0 = 9'($urandom); e1 = 9'($urandom);
        BREADY = 1'b0;
        ahb_write(A_FILLBYTE, {23'h0, b});
        ahb_write(A_FILLCNT, 32'd6);
        ahb_write(A_QUEUE, {23'h0, e0});
        ahb_write(A_QUEUE, {23'h0, e1});
        for (int i = 0; i < 6; i++) exp_q.push_back(b);
        exp_q.push_back(e0); exp_q.push_back(e1);
        BREADY = 1'b1;
        wait_got(8, 40);
        repeat (3) @(negedge HCLK);
        tests++; if (got.size() != 8) begin fails++;
            $display("FAIL pdf_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            tests++; if (got[i] !== exp_q[i]) begin fails++;
                $display("FAIL pdf_data[%0d]: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_err();
        logic [31:0] rd;
        logic [8:0]  e;
        got.delete();
        e = 9'($urandom);
        BREADY = 1'b0;
        ahb_write(A_QUEUE, {23'h0, e});
        ahb_write(A_FILLCNT, 32'd5);
        ahb_read(A_STATUS, rd);
        tests++; if (rd !== 32'h68) begin fails++;
            $display("FAIL err_status: got %h expected 00000068", rd); end
        BREADY = 1'b1;
        repeat (30) @(negedge HCLK);
        tests++; if (got.size() != 1 || got[0] !== e) begin fails++;
            $display("FAIL err_nofill: got %0d bytes expected 1 byte %h", got.size(), e); end
        ahb_write(A_STATUS, 32'h41);
        ahb_write(A_FILLCNT, 32'd0);
        repeat (10) @(negedge HCLK);
        ahb_read(A_STATUS, rd);
        tests++; if (rd !== 32'h42 || got.size() != 1) begin fails++;
            $display("FAIL err_clear_n0: status %h bytes %0d expected 00000042 and 1", rd, got.size()); end
    endtask

    task automatic test_random_stall();
        int n;
        logic [8:0] v[8];
        for (int r = 0; r < 4; r++) begin
            got.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) v[i] = 9'($urandom);
            BREADY = 1'b0;
            fork
                for (int i = 0; i < n; i++) ahb_write(A_QUEUE, {23'h0, v[i]});
                for (int c = 0; c < 300 && got.size() < n; c++) begin
                    @(negedge HCLK); BREADY = 1'($urandom);
                end
            join
            BREADY = 1'b1;
            repeat (3) @(negedge HCLK);
            tests++; if (got.size() != n) begin fails++;
                $display("FAIL stall_count: got %0d expected %0d", got.size(), n); end
            for (int i = 0; i < n && i < got.size(); i++) begin
                tests++; if (got[i] !== v[i]) begin fails++;
                    $display("FAIL stall_order[%0d]: got %h expected %h", i, got[i], v[i]); end
            end
        end
        tests++; if (stall_viol != 0) begin fails++;
            $display("FAIL stall_stable: got %0d changes while stalled expected 0", stall_viol); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd;
        got.delete();
        BREADY = 1'b0;
        for (int i = 0; i < 4; i++) ahb_write(A_QUEUE, $urandom & 32'h1FF);
        @(negedge HCLK);
        tests++; if (BVALID !== 1'b1) begin fails++;
            $display("FAIL rst_pre_bvalid: got %b expected 1", BVALID); end
        HRESET = 1'b1;
        @(negedge HCLK);
        tests++; if ({BVALID, BDNC, BDATA} !== 10'h0 || IRQ !== 1'b0) begin fails++;
            $display("FAIL rst_mid_out: got %h irq %b expected 000/0", {BVALID, BDNC, BDATA}, IRQ); end
        HRESET = 1'b0;
        ahb_read(A_STATUS, rd);
        tests++; if (rd !== 32'h2) begin fails++;
            $display("FAIL rst_mid_status: got %h expected 00000002", rd); end
        BREADY = 1'b1;
        repeat (10) @(negedge HCLK);
        tests++; if (got.size() != 0) begin fails++;
            $display("FAIL rst_mid_flush: got %0d bytes expected 0", got.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_fill();
        test_fill_random();
        test_push_during_fill();
        test_err();
        test_random_stall();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
